spi_responder: RTL and testbench

- SPI slave/responder: the far end of the team's SPI master link.
- Mode 3 (CPOL=1, CPHA=1), MSB first, active-low enable.
- Oversamples the SPI pins in the clk domain. Returns a byte on spi_miso while receiving a byte on spi_mosi.
- Sits behind a pin pad and feeds a register-file/command decoder through a one-deep transmit holding register and a pulsed receive interface.

---
 rtl/spi_responder_if.sv | 14 +
 rtl/spi_responder.sv | 121 ++++++++++++
 tb/tb_spi_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_responder_if.sv
// spi_responder_if: SPI pad pins plus the host-side tx/rx signals of spi_responder.
interface spi_responder_if #(parameter int DATA_W = 8);
  logic spi_clk, spi_en, spi_mosi, spi_miso, spi_miso_oe;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic tx_wr, tx_empty, rx_valid, tx_underrun, frame_abort, busy;
  modport slave (
    input  spi_clk, spi_en, spi_mosi, tx_data, tx_wr,
    output spi_miso, spi_miso_oe, tx_empty, rx_data, rx_valid, tx_underrun, frame_abort, busy
  );
  modport master (
    output spi_clk, spi_en, spi_mosi, tx_data, tx_wr,
    input  spi_miso, spi_miso_oe, tx_empty, rx_data, rx_valid, tx_underrun, frame_abort, busy
  );
endinterface

// File: rtl/spi_responder.sv
// spi_responder: mode-3 SPI slave, pins oversampled in clk, one-deep tx holding register, pulsed rx.
module spi_responder #(
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_WORD = 8'hFF
) (
  input logic clk,
  input logic rst,
  spi_responder_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [SYNC_STAGES-1:0] sclk_q, en_q, mosi_q;
  logic sclk_dly_q, en_dly_q;
  logic [0:0] state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic tx_empty_q, tx_empty_d, miso_q, miso_d, oe_q, oe_d, done_q, done_d;
  logic rx_valid_q, underrun_q, underrun_d, abort_q, abort_d;
  logic sclk_s, en_s, mosi_s, sclk_rise, sclk_fall, en_rise, en_fall, last, load;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign en_s      = en_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign en_rise   = en_s & ~en_dly_q;
  assign en_fall   = ~en_s & en_dly_q;
  assign last      = bit_cnt_q == LAST;
  // a word is loaded at frame start and again when each word completes
  assign load      = (state_q == IDLE) ? en_fall : sclk_rise & last;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    hold_d     = bus.tx_wr ? bus.tx_data : hold_q;
    tx_empty_d = load ? 1'b1 : bus.tx_wr ? 1'b0 : tx_empty_q;
    underrun_d = load & tx_empty_q & ~bus.tx_wr;
    rx_data_d  = done_q ? rx_shift_q : rx_data_q;
    if (state_q == IDLE) begin
      if (en_fall) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
        oe_d      = 1'b1;
      end
    end else begin
      if (sclk_fall) begin
        miso_d     = tx_shift_q[DATA_W-1];
        tx_shift_d = tx_shift_q << 1;
      end
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
        bit_cnt_d  = last ? '0 : bit_cnt_q + CW'(1);
        done_d     = last;
      end
      if (en_rise) begin
        state_d = IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
        abort_d = bit_cnt_d != '0;
      end
    end
    if (load) tx_shift_d = bus.tx_wr ? bus.tx_data : tx_empty_q ? UNDERRUN_WORD : hold_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q     <= '1;
      en_q       <= '1;
      mosi_q     <= '0;
      sclk_dly_q <= 1'b1;
      en_dly_q   <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_empty_q <= 1'b1;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], bus.spi_clk};
      en_q       <= {en_q[SYNC_STAGES-2:0], bus.spi_en};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_dly_q <= sclk_s;
      en_dly_q   <= en_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      tx_empty_q <= tx_empty_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      rx_valid_q <= done_q;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end
  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.tx_empty    = tx_empty_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_abort = abort_q;
  assign bus.busy        = state_q == SHIFT;
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: SPI master model driving spi_responder, table vectors, corner sequences, random frames.
module tb_spi_responder;
  localparam int HP = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_responder_if #(.DATA_W(8)) bus ();
  spi_responder #(.DATA_W(8), .SYNC_STAGES(2), .UNDERRUN_WORD(8'hFF)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;
  int und_mark = 0;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rxv_cnt++;
      rx_q.push_back(bus.rx_data);
    end
    if (bus.tx_underrun) und_cnt++;
    if (bus.frame_abort) abt_cnt++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  typedef struct {
    logic       wr;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr_tx(input logic [7:0] v);
    bus.tx_data = v;
    bus.tx_wr = 1'b1;
    cyc(1);
    bus.tx_wr = 1'b0;
  endtask
  // one word, MSB first; optional tx write during bit 3; optional en release on the final rising edge
  task automatic word(input logic [7:0] mo, input bit do_wr, input logic [7:0] wv, input bit end_frame,
                      output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_clk = 1'b0;
      bus.spi_mosi = mo[i];
      if (i == 3 && do_wr) begin
        cyc(1);
        wr_tx(wv);
        cyc(HP - 2);
      end else cyc(HP);
      mi[i] = bus.spi_miso;
      if (i == 0) und_mark = und_cnt;
      bus.spi_clk = 1'b1;
      if (i == 0 && end_frame) bus.spi_en = 1'b1;
      cyc(HP);
    end
  endtask
  task automatic frame1(input logic [7:0] mo, output logic [7:0] mi);
    bus.spi_en = 1'b0;
    cyc(HP);
    word(mo, 1'b0, 8'h00, 1'b0, mi);
    bus.spi_en = 1'b1;
    cyc(HP + 4);
  endtask
  initial begin
    logic [7:0] mi, mi2, v, mo, wv, nextw, hval, rxd0;
    logic hv, dw;
    int r0, u0, a0, nw, exp_und;
    logic [7:0] sent[$];
    bus.spi_clk = 1'b1;
    bus.spi_en = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_wr = 1'b0;
    vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vt[1] = '{1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 1};
    vt[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vt[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 0};
    vt[4] = '{1'b1, 8'h6E, 8'h00, 8'h6E, 8'h00, 0};
    cyc(3);
    chk("rst_empty", 32'(bus.tx_empty), 1);
    chk("rst_oe_busy_miso", 32'({bus.spi_miso_oe, bus.busy, bus.spi_miso}), 0);
    chk("rst_rx", 32'(bus.rx_data), 0);
    rst = 1'b0;
    cyc(3);
    foreach (vt[k]) begin
      if (vt[k].wr) wr_tx(vt[k].tx);
      r0 = rxv_cnt; u0 = und_cnt;
      rx_q.delete();
      frame1(vt[k].mosi, mi);
      chk("tbl_miso", 32'(mi), 32'(vt[k].exp_miso));
      chk("tbl_und_word", und_mark - u0, vt[k].exp_und);
      chk("tbl_und_total", und_cnt - u0, vt[k].exp_und + 1);
      chk("tbl_rxv", rxv_cnt - r0, 1);
      chk("tbl_rx", 32'(bus.rx_data), 32'(vt[k].exp_rx));
      chk("tbl_empty", 32'(bus.tx_empty), 1);
      chk("tbl_oe", 32'(bus.spi_miso_oe), 0);
    end
    // two-word frame, second word written after the first load
    wr_tx(8'h11);
    r0 = rxv_cnt; rx_q.delete();
    bus.spi_en = 1'b0;
    cyc(HP);
    chk("two_busy", 32'(bus.busy), 1);
    word(8'h81, 1'b1, 8'h22, 1'b0, mi);
    word(8'h7E, 1'b0, 8'h00, 1'b0, mi2);
    bus.spi_en = 1'b1;
    cyc(HP + 4);
    chk("two_miso0", 32'(mi), 32'h11);
    chk("two_miso1", 32'(mi2), 32'h22);
    chk("two_rxv", rxv_cnt - r0, 2);
    chk("two_rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hXX), 32'h81);
    chk("two_rx1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hXX), 32'h7E);
    // abort after three rising edges
    r0 = rxv_cnt; a0 = abt_cnt; rxd0 = bus.rx_data;
    bus.spi_en = 1'b0;
    cyc(HP);
    for (int i = 0; i < 3; i++) begin
      bus.spi_clk = 1'b0;
      bus.spi_mosi = 1'($urandom);
      cyc(HP);
      bus.spi_clk = 1'b1;
      cyc(HP);
    end
    bus.spi_en = 1'b1;
    cyc(HP + 4);
    chk("abort_pulse", abt_cnt - a0, 1);
    chk("abort_rxv", rxv_cnt - r0, 0);
    chk("abort_rx", 32'(bus.rx_data), 32'(rxd0));
    chk("abort_oe_busy", 32'({bus.spi_miso_oe, bus.busy}), 0);
    wr_tx(8'h6B);
    frame1(8'h94, mi);
    chk("post_abort_miso", 32'(mi), 32'h6B);
    chk("post_abort_rx", 32'(bus.rx_data), 32'h94);
    // bypass: tx_wr in the cycle the synchronized en falling edge loads
    u0 = und_cnt;
    bus.spi_en = 1'b0;
    cyc(2);
    bus.tx_data = 8'h9C;
    bus.tx_wr = 1'b1;
    cyc(1);
    bus.tx_wr = 1'b0;
    cyc(HP - 3);
    chk("byp_empty", 32'(bus.tx_empty), 1);
    word(8'h3A, 1'b0, 8'h00, 1'b0, mi);
    bus.spi_en = 1'b1;
    cyc(HP + 4);
    chk("byp_miso", 32'(mi), 32'h9C);
    chk("byp_und_word", und_mark - u0, 0);
    // word completion and en release on the same synchronized edge
    wr_tx(8'hE7);
    r0 = rxv_cnt; a0 = abt_cnt;
    bus.spi_en = 1'b0;
    cyc(HP);
    word(8'h5D, 1'b0, 8'h00, 1'b1, mi);
    cyc(HP + 4);
    chk("simul_rxv", rxv_cnt - r0, 1);
    chk("simul_abort", abt_cnt - a0, 0);
    chk("simul_rx", 32'(bus.rx_data), 32'h5D);
    chk("simul_miso", 32'(mi), 32'hE7);
    // reset in the middle of a word
    wr_tx(8'h5A);
    bus.spi_en = 1'b0;
    cyc(HP);
    for (int i = 0; i < 5; i++) begin
      bus.spi_clk = 1'b0;
      bus.spi_mosi = 1'b1;
      cyc(HP);
      bus.spi_clk = 1'b1;
      cyc(HP);
    end
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_pins", 32'({bus.spi_miso, bus.spi_miso_oe, bus.busy}), 0);
    chk("mid_rst_pulses", 32'({bus.rx_valid, bus.tx_underrun, bus.frame_abort}), 0);
    chk("mid_rst_rx", 32'(bus.rx_data), 0);
    chk("mid_rst_empty", 32'(bus.tx_empty), 1);
    bus.spi_en = 1'b1;
    bus.spi_clk = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_idle", 32'(bus.busy), 0);
    wr_tx(8'hC3);
    frame1(8'h0F, mi);
    chk("post_rst_miso", 32'(mi), 32'hC3);
    chk("post_rst_rx", 32'(bus.rx_data), 32'h0F);
    // random multi-word frames against a holding-register model
    hv = 1'b0; hval = '0;
    for (int f = 0; f < 30; f++) begin
      nw = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom); wr_tx(v); hv = 1'b1; hval = v;
        if ($urandom_range(0, 1) == 1) begin
          v = 8'($urandom); wr_tx(v); hval = v;
        end
      end
      r0 = rxv_cnt; u0 = und_cnt; a0 = abt_cnt; exp_und = 0;
      rx_q.delete(); sent.delete();
      bus.spi_en = 1'b0;
      cyc(HP);
      nextw = hv ? hval : 8'hFF; exp_und += hv ? 0 : 1; hv = 1'b0;
      for (int w = 0; w < nw; w++) begin
        mo = 8'($urandom); dw = 1'($urandom); wv = 8'($urandom);
        word(mo, dw, wv, 1'b0, mi);
        chk("rnd_miso", 32'(mi), 32'(nextw));
        if (dw) begin hv = 1'b1; hval = wv; end
        nextw = hv ? hval : 8'hFF; exp_und += hv ? 0 : 1; hv = 1'b0;
        sent.push_back(mo);
      end
      bus.spi_en = 1'b1;
      cyc(HP + 4);
      chk("rnd_rxv", rxv_cnt - r0, nw);
      chk("rnd_und", und_cnt - u0, exp_und);
      chk("rnd_abort", abt_cnt - a0, 0);
      chk("rnd_empty", 32'(bus.tx_empty), 32'(!hv));
      foreach (sent[j]) chk("rnd_rx", 32'(j < rx_q.size() ? rx_q[j] : 8'hXX), 32'(sent[j]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
